// File: rtl/ahb_lite_master.sv
// Single-channel AHB-Lite initiator: takes one command at a time and runs it as a
// pipelined SINGLE/INCR/WRAP burst, streaming write data in and read data out.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [4:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic [1:0]            HRESP,
  input  logic                  HREADY
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR2} state_t;

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t     state;
  logic [4:0] beats_left;

  // Command legality, evaluated on the raw command inputs
  logic [4:0]            cmd_beats;
  logic [10:0]           size_bits;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [11:0]           span;
  logic                  size_ok, align_ok, len_ok, cross_1k, cmd_ok;

  always_comb begin
    cmd_beats = 5'd1;
    case (cmd_burst)
      3'b000:         cmd_beats = 5'd1;
      3'b001:         cmd_beats = cmd_len;
      3'b010, 3'b011: cmd_beats = 5'd4;
      3'b100, 3'b101: cmd_beats = 5'd8;
      default:        cmd_beats = 5'd16;
    endcase
  end

  assign size_bits  = 11'd8 << cmd_size;
  assign size_ok    = int'(size_bits) <= DATA_WIDTH;
  assign align_mask = ~({ADDR_WIDTH{1'b1}} << cmd_size);
  assign align_ok   = (cmd_addr & align_mask) == '0;
  assign len_ok     = (cmd_burst != 3'b001) || ((cmd_len != 5'd0) && (cmd_len <= 5'd16));
  assign span       = {7'b0, cmd_beats} << cmd_size;
  // burst[0] set marks the incrementing types; they must stay inside one 1KB page
  assign cross_1k   = cmd_burst[0] && (({2'b0, cmd_addr[9:0]} + span) > 12'd1024);
  assign cmd_ok     = size_ok && align_ok && len_ok && !cross_1k;

  // Next beat address from the latched transfer attributes on the bus
  logic [4:0]            wrap_n;
  logic                  is_wrap;
  logic [ADDR_WIDTH-1:0] step, incr_addr, wrap_mask, next_addr;

  always_comb begin
    wrap_n = 5'd1;
    case (HBURST[2:1])
      2'b01:   wrap_n = 5'd4;
      2'b10:   wrap_n = 5'd8;
      2'b11:   wrap_n = 5'd16;
      default: wrap_n = 5'd1;
    endcase
  end

  assign is_wrap   = !HBURST[0] && (HBURST != 3'b000);
  assign step      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << HSIZE;
  assign incr_addr = HADDR + step;
  assign wrap_mask = ({{(ADDR_WIDTH-5){1'b0}}, wrap_n} << HSIZE) - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign next_addr = is_wrap ? ((HADDR & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

  assign cmd_ready = (state == S_IDLE);
  assign wdata_ack = HTRANS[1] && HWRITE && HREADY;
  assign HPROT     = 4'b0011;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      beats_left <= '0;
      HADDR      <= '0;
      HTRANS     <= TR_IDLE;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      HBURST     <= '0;
      HWDATA     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (!cmd_ok) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              HADDR      <= cmd_addr;
              HTRANS     <= TR_NONSEQ;
              HWRITE     <= cmd_write;
              HSIZE      <= cmd_size;
              HBURST     <= cmd_burst;
              beats_left <= cmd_beats;
              state      <= S_ADDR;
            end
          end
        end
        S_ADDR, S_BURST: begin
          if (state == S_BURST && HRESP == RESP_ERROR && !HREADY) begin
            HTRANS <= TR_IDLE;
            state  <= S_ERR2;
          end else if (HREADY) begin
            // S_BURST also closes the previous beat's data phase on this edge
            if (state == S_BURST && !HWRITE && HRESP == RESP_OKAY) begin
              rd_data  <= HRDATA;
              rd_valid <= 1'b1;
            end
            if (HWRITE) HWDATA <= wdata;
            if (beats_left == 5'd1) begin
              HTRANS <= TR_IDLE;
              state  <= S_LAST;
            end else begin
              HADDR      <= next_addr;
              HTRANS     <= TR_SEQ;
              beats_left <= beats_left - 5'd1;
              state      <= S_BURST;
            end
          end
        end
        S_LAST: begin
          if (HRESP == RESP_ERROR && !HREADY) begin
            state <= S_ERR2;
          end else if (HREADY) begin
            if (!HWRITE && HRESP == RESP_OKAY) begin
              rd_data  <= HRDATA;
              rd_valid <= 1'b1;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ERR2: begin
          if (HREADY) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a scripted slave with per-beat wait/error
// injection, per-cycle bus logs, and hand-computed expectations per scenario.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size, cmd_burst;
  logic [4:0]  cmd_len;
  logic [31:0] wdata, rd_data;
  logic        wdata_ack, rd_valid, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int total = 0;
  int bad = 0;

  logic [31:0] a_log [32];
  logic [1:0]  t_log [32];
  logic [31:0] w_log [32];
  logic [31:0] wd_log[32];
  logic [31:0] rd_log[32];
  logic [1:0]  trans_err2;
  int          n_addr, n_wait, n_wack, n_rd, n_active, done_cyc, first_ns;
  logic        err_flag, ready_at_done;

  ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  // Drives one command from cycle 0 and plays the slave until done (or 200 cycles).
  task automatic run_cmd(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [2:0] bu, input logic [4:0] ln, input logic [31:0] wbase,
                         input int wait_beat, input int wait_n, input int err_beat);
    bit dp = 0;
    bit err2;
    int dpb = 0, nb = 0, waits = 0, ep = 0;
    n_addr = 0; n_wait = 0; n_wack = 0; n_rd = 0; n_active = 0;
    done_cyc = -1; first_ns = -1; err_flag = 1'b0; ready_at_done = 1'b0; trans_err2 = 2'b10;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge HCLK);
      cmd_valid = (cyc == 0);
      if (rd_valid && n_rd < 32) begin rd_log[n_rd] = rd_data; n_rd++; end
      if (cyc > 0 && done) begin
        done_cyc = cyc; err_flag = err; ready_at_done = cmd_ready;
        break;
      end
      if (cyc == 0) begin
        cmd_addr = a; cmd_write = wr; cmd_size = sz; cmd_burst = bu; cmd_len = ln;
      end
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0; err2 = 1'b0;
      if (dp) begin
        if (dpb == err_beat) begin
          HRESP = 2'b01;
          if (ep == 0) begin HREADY = 1'b0; ep = 1; end
          else err2 = 1'b1;
        end else if (dpb == wait_beat && waits < wait_n) begin
          HREADY = 1'b0; waits++;
        end else begin
          HRDATA = 32'hA000_0000 + 32'(dpb);
        end
      end
      wdata = wbase + 32'(n_wack);
      #1;
      if (HTRANS != 2'b00) n_active++;
      if (err2) trans_err2 = HTRANS;
      if (HTRANS == 2'b10 && first_ns < 0) first_ns = cyc;
      if (HTRANS[1] && HREADY && n_addr < 32) begin
        a_log[n_addr] = HADDR; t_log[n_addr] = HTRANS; n_addr++;
      end else if (HTRANS[1] && n_wait < 32) begin
        w_log[n_wait] = HADDR; n_wait++;
      end
      if (wdata_ack) n_wack++;
      if (dp && wr && HREADY && HRESP == 2'b00 && dpb >= 1 && dpb <= 32) wd_log[dpb-1] = HWDATA;
      if (err2) dp = 0;
      else if (HREADY) begin
        if (HTRANS[1]) begin dp = 1; nb++; dpb = nb; end
        else dp = 0;
      end
    end
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0; cmd_burst = '0;
    cmd_len = '0; wdata = '0; HRDATA = '0; HRESP = 2'b00; HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%h exp=0", HTRANS); end
    total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
    total++; if (HPROT !== 4'b0011) begin bad++; $display("FAIL rst_hprot got=%h exp=3", HPROT); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    total++; if ({done, err, rd_valid, wdata_ack} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=0000", {done, err, rd_valid, wdata_ack}); end
    total++; if (rd_data !== 32'h0 || HWDATA !== 32'h0) begin
      bad++; $display("FAIL rst_data got=%h/%h exp=0/0", rd_data, HWDATA); end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write;
    run_cmd(32'h04, 1'b1, 3'd2, 3'b000, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    total++; if (first_ns != 1) begin bad++; $display("FAIL sw_nonseq_cyc got=%0d exp=1", first_ns); end
    total++; if (n_addr != 1 || a_log[0] !== 32'h04 || t_log[0] !== 2'b10) begin
      bad++; $display("FAIL sw_addr got=%0d/%h/%h exp=1/00000004/2", n_addr, a_log[0], t_log[0]); end
    total++; if (wd_log[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_hwdata got=%h exp=deadbeef", wd_log[0]); end
    total++; if (n_wack != 1) begin bad++; $display("FAIL sw_wack got=%0d exp=1", n_wack); end
    total++; if (done_cyc != 3 || err_flag !== 1'b0) begin
      bad++; $display("FAIL sw_done got=%0d/%b exp=3/0", done_cyc, err_flag); end
  endtask

  task automatic test_incr4_wait;
    logic [31:0] ea[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [1:0]  et[4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    run_cmd(32'h100, 1'b0, 3'd2, 3'b011, 5'd0, 32'h0, 2, 2, 0);
    total++; if (n_addr != 4) begin bad++; $display("FAIL i4_naddr got=%0d exp=4", n_addr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (a_log[i] !== ea[i] || t_log[i] !== et[i]) begin
        bad++; $display("FAIL i4_beat%0d got=%h/%h exp=%h/%h", i, a_log[i], t_log[i], ea[i], et[i]); end
    end
    total++; if (n_wait != 2 || w_log[0] !== 32'h108 || w_log[1] !== 32'h108) begin
      bad++; $display("FAIL i4_hold got=%0d/%h/%h exp=2/108/108", n_wait, w_log[0], w_log[1]); end
    total++; if (n_rd != 4) begin bad++; $display("FAIL i4_nrd got=%0d exp=4", n_rd); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_log[i] !== 32'hA000_0001 + 32'(i)) begin
        bad++; $display("FAIL i4_rd%0d got=%h exp=%h", i, rd_log[i], 32'hA000_0001 + 32'(i)); end
    end
    total++; if (done_cyc != 8 || err_flag !== 1'b0) begin
      bad++; $display("FAIL i4_done got=%0d/%b exp=8/0", done_cyc, err_flag); end
  endtask

  task automatic test_wrap4_write;
    logic [31:0] ea[4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic [1:0]  et[4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    run_cmd(32'h38, 1'b1, 3'd2, 3'b010, 5'd0, 32'hC0DE_0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (a_log[i] !== ea[i] || t_log[i] !== et[i]) begin
        bad++; $display("FAIL w4_beat%0d got=%h/%h exp=%h/%h", i, a_log[i], t_log[i], ea[i], et[i]); end
      total++; if (wd_log[i] !== 32'hC0DE_0000 + 32'(i)) begin
        bad++; $display("FAIL w4_hwdata%0d got=%h exp=%h", i, wd_log[i], 32'hC0DE_0000 + 32'(i)); end
    end
    total++; if (n_wack != 4) begin bad++; $display("FAIL w4_wack got=%0d exp=4", n_wack); end
    total++; if (done_cyc != 6 || err_flag !== 1'b0) begin
      bad++; $display("FAIL w4_done got=%0d/%b exp=6/0", done_cyc, err_flag); end
  endtask

  task automatic test_incr_len;
    logic [31:0] ea[3] = '{32'h10, 32'h12, 32'h14};
    run_cmd(32'h10, 1'b1, 3'd1, 3'b001, 5'd3, 32'h0, 0, 0, 0);
    total++; if (n_addr != 3) begin bad++; $display("FAIL il_naddr got=%0d exp=3", n_addr); end
    for (int i = 0; i < 3; i++) begin
      total++; if (a_log[i] !== ea[i]) begin
        bad++; $display("FAIL il_beat%0d got=%h exp=%h", i, a_log[i], ea[i]); end
    end
    total++; if (done_cyc != 5 || err_flag !== 1'b0) begin
      bad++; $display("FAIL il_done got=%0d/%b exp=5/0", done_cyc, err_flag); end
  endtask

  task automatic test_incr8_error;
    run_cmd(32'h200, 1'b0, 3'd2, 3'b101, 5'd0, 32'h0, 0, 0, 3);
    total++; if (n_rd != 2) begin bad++; $display("FAIL e8_nrd got=%0d exp=2", n_rd); end
    total++; if (rd_log[0] !== 32'hA000_0001 || rd_log[1] !== 32'hA000_0002) begin
      bad++; $display("FAIL e8_rd got=%h/%h exp=a0000001/a0000002", rd_log[0], rd_log[1]); end
    total++; if (trans_err2 !== 2'b00) begin bad++; $display("FAIL e8_htrans_err2 got=%h exp=0", trans_err2); end
    total++; if (n_addr != 3) begin bad++; $display("FAIL e8_naddr got=%0d exp=3", n_addr); end
    total++; if (done_cyc != 6 || err_flag !== 1'b1) begin
      bad++; $display("FAIL e8_done got=%0d/%b exp=6/1", done_cyc, err_flag); end
  endtask

  task automatic test_reject;
    run_cmd(32'h3FC, 1'b0, 3'd2, 3'b011, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 1 || err_flag !== 1'b1 || n_active != 0) begin
      bad++; $display("FAIL rj_1k got=%0d/%b/%0d exp=1/1/0", done_cyc, err_flag, n_active); end
    run_cmd(32'h02, 1'b0, 3'd2, 3'b000, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 1 || err_flag !== 1'b1 || n_active != 0) begin
      bad++; $display("FAIL rj_align got=%0d/%b/%0d exp=1/1/0", done_cyc, err_flag, n_active); end
    run_cmd(32'h40, 1'b0, 3'd2, 3'b001, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 1 || err_flag !== 1'b1 || n_active != 0) begin
      bad++; $display("FAIL rj_len0 got=%0d/%b/%0d exp=1/1/0", done_cyc, err_flag, n_active); end
    run_cmd(32'h40, 1'b0, 3'd3, 3'b000, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 1 || err_flag !== 1'b1 || n_active != 0) begin
      bad++; $display("FAIL rj_size got=%0d/%b/%0d exp=1/1/0", done_cyc, err_flag, n_active); end
    run_cmd(32'h3F0, 1'b0, 3'd2, 3'b011, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 6 || err_flag !== 1'b0 || n_addr != 4 || a_log[3] !== 32'h3FC) begin
      bad++; $display("FAIL rj_edge_ok got=%0d/%b/%0d/%h exp=6/0/4/000003fc", done_cyc, err_flag, n_addr, a_log[3]); end
  endtask

  task automatic test_back_to_back;
    run_cmd(32'h80, 1'b1, 3'd2, 3'b000, 5'd0, 32'h1234_5678, 0, 0, 0);
    total++; if (done_cyc != 3 || ready_at_done !== 1'b1 || wd_log[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL bb_first got=%0d/%b/%h exp=3/1/12345678", done_cyc, ready_at_done, wd_log[0]); end
    run_cmd(32'h84, 1'b0, 3'd2, 3'b000, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 3 || n_rd != 1 || rd_log[0] !== 32'hA000_0001 || a_log[0] !== 32'h84) begin
      bad++; $display("FAIL bb_second got=%0d/%0d/%h/%h exp=3/1/a0000001/00000084", done_cyc, n_rd, rd_log[0], a_log[0]); end
  endtask

  task automatic test_reset_mid;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_size = 3'd2;
    cmd_burst = 3'b111; cmd_len = 5'd0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h5555_AAAA;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge HCLK);
    total++; if (HTRANS !== 2'b11 || HADDR !== 32'hC || rd_data !== 32'h5555_AAAA) begin
      bad++; $display("FAIL rm_before got=%h/%h/%h exp=3/0000000c/5555aaaa", HTRANS, HADDR, rd_data); end
    #2 HRESETn = 1'b0;
    #1;
    total++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HBURST !== 3'b0 || HSIZE !== 3'b0 || HWRITE !== 1'b0) begin
      bad++; $display("FAIL rm_bus got=%h/%h/%h/%h/%b exp=0/0/0/0/0", HTRANS, HADDR, HBURST, HSIZE, HWRITE); end
    total++; if (rd_data !== 32'h0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0 || HPROT !== 4'b0011) begin
      bad++; $display("FAIL rm_ctl got=%h/%b/%b/%h exp=0/1/0/3", rd_data, cmd_ready, rd_valid, HPROT); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_cmd(32'h40, 1'b0, 3'd2, 3'b000, 5'd0, 32'h0, 0, 0, 0);
    total++; if (done_cyc != 3 || err_flag !== 1'b0 || n_rd != 1 || rd_log[0] !== 32'hA000_0001) begin
      bad++; $display("FAIL rm_after got=%0d/%b/%0d/%h exp=3/0/1/a0000001", done_cyc, err_flag, n_rd, rd_log[0]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_wait();
    test_wrap4_write();
    test_incr_len();
    test_incr8_error();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
